text_console_16x16: RTL and testbench

- Writable 16x16 character buffer: the write-side counterpart to the fixed character ROMs.
- A producer (keyboard/UART decoder, game FSM) streams character codes in with a valid/ready handshake.
- The block handles the cursor, CR/LF/backspace, clear and an optional scroll.
- The display side reads through a ROM-compatible port: 8-bit char_xy in, 7-bit char code out, 1-cycle latency. It drops in where a char_rom_* block is used today.

---
 rtl/text_pkg.sv | 34 +++
 rtl/char_ram_256x7_dp.sv | 46 ++++
 rtl/text_console_16x16.sv | 178 +++++++++++++++++
 tb/tb_text_console_16x16.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// ----------------------------------------------------------------------------
// text_pkg: shared types and constants for the 16x16 text console.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package text_pkg;

  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 16;
  localparam int CELL_W    = 7;
  localparam int CELLS     = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W    = $clog2(CELLS);

  localparam logic [CELL_W-1:0] CHAR_CR = 7'h0D;
  localparam logic [CELL_W-1:0] CHAR_LF = 7'h0A;
  localparam logic [CELL_W-1:0] CHAR_BS = 7'h08;

`ifdef TEXT_CONSOLE_SCROLL_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1
  } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/char_ram_256x7_dp.sv
// ----------------------------------------------------------------------------
// char_ram_256x7_dp: 256x7 RAM, registered display read port plus an
// owner port with independent read and write addresses. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module char_ram_256x7_dp
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic [CELL_W-1:0] a_rdata_o,
  input  logic [ADDR_W-1:0] b_raddr_i,
  output logic [CELL_W-1:0] b_rdata_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_waddr_i,
  input  logic [CELL_W-1:0] b_wdata_i
);

  logic [CELL_W-1:0] mem [0:CELLS-1];
  logic [CELL_W-1:0] a_rdata_q;
  logic [CELL_W-1:0] b_rdata_q;

  // Array is deliberately not reset; reads see pre-write data on collision.
  always_ff @(posedge clk) begin
    if (b_we_i) begin
      mem[b_waddr_i] <= b_wdata_i;
    end
    b_rdata_q <= mem[b_raddr_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem[a_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

`default_nettype wire

// File: rtl/text_console_16x16.sv
// ----------------------------------------------------------------------------
// text_console_16x16: writable 16x16 character buffer with cursor, CR/LF/BS
// and clear. Optional scroll via TEXT_CONSOLE_SCROLL_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module text_console_16x16
  import text_pkg::*;
#(
  parameter logic [CELL_W-1:0] BLANK_CODE     = 7'h20,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CELL_W-1:0] wr_char,
  input  logic              clear,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [CELL_W-1:0] char_code_out,
  output logic [ADDR_W-1:0] cursor_xy,
  output logic              busy
);

  localparam logic [8:0] CLEAR_LAST = 9'd255;
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [8:0] SCROLL_FILL_START = 9'd241;
  localparam logic [8:0] SCROLL_LAST       = 9'd256;
`endif

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              past_end;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [CELL_W-1:0] ram_wdata;
  logic [CELL_W-1:0] scroll_rdata;

  char_ram_256x7_dp u_ram (
    .clk       (clk),
    .rst       (rst),
    .a_addr_i  (char_xy),
    .a_rdata_o (char_code_out),
    .b_raddr_i (ram_raddr),
    .b_rdata_o (scroll_rdata),
    .b_we_i    (ram_we),
    .b_waddr_i (ram_waddr),
    .b_wdata_i (ram_wdata)
  );

`ifndef TEXT_CONSOLE_SCROLL_EN
  logic unused_rdata;
  assign unused_rdata = ^scroll_rdata;
`endif

  assign wr_ready  = (state_q == ST_IDLE) && !clear;
  assign busy      = (state_q != ST_IDLE);
  assign cursor_xy = cursor_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cursor_d  = cursor_q;
    past_end  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cursor_q;
    ram_wdata = wr_char;
    ram_raddr = '0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d  = ST_CLEAR;
          cnt_d    = '0;
          cursor_d = '0;
        end else if (wr_valid) begin
          case (wr_char)
            CHAR_CR: cursor_d = {cursor_q[7:4], 4'h0};
            CHAR_LF: begin
              if (cursor_q[7:4] == 4'hF) begin
                past_end = 1'b1;
              end else begin
                cursor_d = {cursor_q[7:4] + 4'd1, 4'h0};
              end
            end
            CHAR_BS: begin
              ram_we    = 1'b1;
              ram_wdata = BLANK_CODE;
              if (cursor_q != '0) begin
                ram_waddr = cursor_q - 8'd1;
                cursor_d  = cursor_q - 8'd1;
              end
            end
            default: begin
              ram_we = 1'b1;
              if (cursor_q == 8'hFF) begin
                past_end = 1'b1;
              end else begin
                cursor_d = cursor_q + 8'd1;
              end
            end
          endcase
        end
      end

      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q[7:0];
        ram_wdata = BLANK_CODE;
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == CLEAR_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

`ifdef TEXT_CONSOLE_SCROLL_EN
      // Copy writes trail reads by one cycle; both phases write cnt-1.
      ST_SCROLL: begin
        if (clear) begin
          state_d  = ST_CLEAR;
          cnt_d    = '0;
          cursor_d = '0;
        end else begin
          ram_raddr = cnt_q[7:0] + 8'd16;
          ram_waddr = cnt_q[7:0] - 8'd1;
          if (cnt_q >= SCROLL_FILL_START) begin
            ram_we    = 1'b1;
            ram_wdata = BLANK_CODE;
          end else if (cnt_q != '0) begin
            ram_we    = 1'b1;
            ram_wdata = scroll_rdata;
          end
          if (cnt_q == SCROLL_LAST) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            cursor_d = 8'hF0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (past_end) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      state_d = ST_SCROLL;
      cnt_d   = '0;
`else
      cursor_d = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q    <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_console_16x16.sv
// ----------------------------------------------------------------------------
// tb_text_console_16x16: vector table, corner sequences and random traffic
// against a cell-array model of the console. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_text_console_16x16;

  localparam logic [6:0] BLANK = 7'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_char = '0;
  logic       clear = 1'b0;
  logic [7:0] char_xy = '0;
  logic       wr_ready;
  logic [6:0] char_code_out;
  logic [7:0] cursor_xy;
  logic       busy;

  text_console_16x16 dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_char       (wr_char),
    .clear         (clear),
    .char_xy       (char_xy),
    .char_code_out (char_code_out),
    .cursor_xy     (cursor_xy),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] mem_m [256];
  int         cur_m;

  typedef struct {
    logic [6:0] ch;
    logic [7:0] cur;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input logic [7:0] addr, input logic [6:0] exp, input string name);
    char_xy = addr;
    @(posedge clk); #1;
    chk(name, 32'(char_code_out), 32'(exp));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = BLANK;
    cur_m = 0;
  endtask

  task automatic model_past_end();
`ifdef TEXT_CONSOLE_SCROLL_EN
    for (int i = 0; i < 240; i++) mem_m[i] = mem_m[i + 16];
    for (int i = 240; i < 256; i++) mem_m[i] = BLANK;
    cur_m = 240;
`else
    cur_m = 0;
`endif
  endtask

  task automatic model_step(input logic [6:0] ch);
    int row, col;
    row = cur_m / 16;
    col = cur_m % 16;
    if (ch == 7'h0D) begin
      cur_m = row * 16;
    end else if (ch == 7'h0A) begin
      if (row == 15) model_past_end();
      else cur_m = (row + 1) * 16;
    end else if (ch == 7'h08) begin
      if (cur_m == 0) mem_m[0] = BLANK;
      else begin
        cur_m = cur_m - 1;
        mem_m[cur_m] = BLANK;
      end
    end else begin
      mem_m[cur_m] = ch;
      if (cur_m == 255) model_past_end();
      else cur_m = row * 16 + col + 1;
    end
  endtask

  task automatic send(input logic [6:0] ch);
    int w;
    w = 0;
    wr_valid = 1'b1;
    wr_char  = ch;
    while (!wr_ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("send_timeout", 32'(w >= 1000), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model_step(ch);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("idle_timeout", 32'(w >= 2000), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  initial begin
    int n;
    logic ready_seen;
    logic [6:0] ch;
    int r;
    int a;

    vecs[0]  = '{7'h57, 8'h01};
    vecs[1]  = '{7'h59, 8'h02};
    vecs[2]  = '{7'h4E, 8'h03};
    vecs[3]  = '{7'h49, 8'h04};
    vecs[4]  = '{7'h4B, 8'h05};
    vecs[5]  = '{7'h0A, 8'h10};
    vecs[6]  = '{7'h41, 8'h11};
    vecs[7]  = '{7'h42, 8'h12};
    vecs[8]  = '{7'h43, 8'h13};
    vecs[9]  = '{7'h0D, 8'h10};
    vecs[10] = '{7'h18, 8'h11};
    vecs[11] = '{7'h08, 8'h10};

    // Reset values and the automatic clear that follows.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   32'(busy), 32'd1);
    chk("reset_ready",  32'(wr_ready), 32'd0);
    chk("reset_cursor", 32'(cursor_xy), 32'h00);
    chk("reset_dout",   32'(char_code_out), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    ready_seen = 1'b0;
    while (busy && n < 2000) begin
      if (wr_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("clear_len",    32'(n), 32'd256);
    chk("clear_ready",  32'(ready_seen), 32'd0);
    chk("clear_cursor", 32'(cursor_xy), 32'h00);
    for (int i = 0; i < 256; i++) rd_chk(8'(i), BLANK, "clear_cell");
    model_clear();

    // Vector table, wr_valid held high back to back.
    wr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_char = vecs[i].ch;
      chk("tbl_ready", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
      chk("tbl_cursor", 32'(cursor_xy), 32'(vecs[i].cur));
      model_step(vecs[i].ch);
    end
    wr_valid = 1'b0;
    rd_chk(8'h00, 7'h57, "tbl_mem0");
    rd_chk(8'h01, 7'h59, "tbl_mem1");
    rd_chk(8'h02, 7'h4E, "tbl_mem2");
    rd_chk(8'h03, 7'h49, "tbl_mem3");
    rd_chk(8'h04, 7'h4B, "tbl_mem4");
    rd_chk(8'h10, BLANK, "tbl_bs_cell");
    rd_chk(8'h11, 7'h42, "tbl_mem11");

    // Backspace across a row boundary.
    send(7'h0A);
    for (int i = 0; i < 16; i++) send(7'h78);
    chk("bs_pre_cursor", 32'(cursor_xy), 32'h30);
    send(7'h08);
    chk("bs_row_cursor", 32'(cursor_xy), 32'h2F);
    rd_chk(8'h2F, BLANK, "bs_row_cell");
    rd_chk(8'h2E, 7'h78, "bs_row_prev");

    // Clear beats a same-cycle character; re-pulse extends the clear.
    wr_valid = 1'b1;
    wr_char  = 7'h41;
    clear    = 1'b1;
    #1;
    chk("col_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    clear    = 1'b0;
    model_clear();
    chk("col_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 2000) begin
      clear = (n == 99);
      @(posedge clk); #1;
      n++;
    end
    clear = 1'b0;
    chk("repulse_len",    32'(n), 32'd356);
    chk("repulse_cursor", 32'(cursor_xy), 32'h00);
    rd_chk(8'h2F, BLANK, "col_not_written");

    // Backspace at the origin.
    send(7'h08);
    chk("bs0_cursor", 32'(cursor_xy), 32'h00);
    rd_chk(8'h00, BLANK, "bs0_cell");

    // Advancing past the last cell.
    send(7'h0A);
    for (int i = 0; i < 16; i++) send(7'h18);
    for (int i = 0; i < 13; i++) send(7'h0A);
    chk("end_row_cursor", 32'(cursor_xy), 32'hF0);
    for (int i = 0; i < 15; i++) send(7'h7A);
    chk("end_cell_cursor", 32'(cursor_xy), 32'hFF);
    send(7'h2E);
`ifdef TEXT_CONSOLE_SCROLL_EN
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scroll_len",    32'(n), 32'd257);
    chk("scroll_cursor", 32'(cursor_xy), 32'hF0);
    for (int i = 0; i < 16; i++) rd_chk(8'(i), 7'h18, "scroll_row0");
    rd_chk(8'hE0, 7'h7A, "scroll_row14");
    rd_chk(8'hEF, 7'h2E, "scroll_trigger");
    for (int i = 240; i < 256; i++) rd_chk(8'(i), BLANK, "scroll_fill");
`else
    chk("wrap_busy",   32'(busy), 32'd0);
    chk("wrap_cursor", 32'(cursor_xy), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_busy_later", 32'(busy), 32'd0);
    rd_chk(8'hFF, 7'h2E, "wrap_last_cell");
    rd_chk(8'h10, 7'h18, "wrap_old_kept");
`endif

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        pulse_clear();
      end else begin
        if (r < 18)      ch = 7'h0A;
        else if (r < 28) ch = 7'h0D;
        else if (r < 43) ch = 7'h08;
        else             ch = 7'($urandom_range(0, 127));
        send(ch);
      end
      wait_idle();
      chk("rand_cursor", 32'(cursor_xy), 32'(cur_m));
      a = int'($urandom_range(0, 255));
      rd_chk(8'(a), mem_m[a], "rand_read");
    end

    for (int i = 0; i < 256; i++) rd_chk(8'(i), mem_m[i], "final_cell");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
